// File: rtl/fifo_read_arbiter.sv
// Round-robin read-side scheduler sharing one FIFO read port among NUM_REQ burst consumers.
// Optional empty-stall abort is enabled by defining ARB_TIMEOUT_EN.
module fifo_read_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned BURST_W = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
    input  logic                       recv_clk,
    input  logic                       trans_rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BURST_W-1:0] burst_len,
    input  logic                       fifo_empty,
    input  logic [DATA_W-1:0]          recv_data,
    output logic                       read_enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic [DATA_W-1:0]          out_data,
    output logic [NUM_REQ-1:0]         out_valid,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic [NUM_REQ-1:0]         abort
`endif
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);
`endif

    typedef enum logic [1:0] {IDLE, GRANT, READ, DRAIN} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gidx;
    logic [BURST_W-1:0] remaining;
    logic [BURST_W-1:0] cur_len;
    logic               pop_d;
    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
`ifdef ARB_TIMEOUT_EN
    logic [STALL_W-1:0] stall_cnt;
`endif

    assign read_enable = (state == READ) && (remaining != '0) && !fifo_empty;
    assign cur_len     = burst_len[32'(gidx) * BURST_W +: BURST_W];

    // First asserted requester after the last-served one, with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!sel_found && req[PTR_W'((32'(ptr) + i) % NUM_REQ)]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'((32'(ptr) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge recv_clk or posedge trans_rst) begin
        if (trans_rst) begin
            state     <= IDLE;
            ptr       <= PTR_W'(NUM_REQ - 1);
            gidx      <= '0;
            grant     <= '0;
            remaining <= '0;
            pop_d     <= 1'b0;
            out_data  <= '0;
            out_valid <= '0;
            done      <= '0;
            busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            abort     <= '0;
            stall_cnt <= '0;
`endif
        end else begin
            // Popped word arrives one cycle after the pop; register it to the owner.
            pop_d     <= read_enable;
            out_valid <= pop_d ? grant : '0;
            if (pop_d) out_data <= recv_data;
            done      <= '0;
`ifdef ARB_TIMEOUT_EN
            abort     <= '0;
`endif
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant <= NUM_REQ'(1) << sel_idx;
                        gidx  <= sel_idx;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    remaining <= cur_len;
`ifdef ARB_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                    if (cur_len == '0) begin
                        done  <= grant;
                        ptr   <= gidx;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (read_enable) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == BURST_W'(1)) state <= DRAIN;
                    end
`ifdef ARB_TIMEOUT_EN
                    if (read_enable) begin
                        stall_cnt <= '0;
                    end else if (fifo_empty && remaining != '0) begin
                        if (stall_cnt == STALL_W'(TIMEOUT_CYC - 1)) begin
                            abort     <= grant;
                            done      <= grant;
                            ptr       <= gidx;
                            grant     <= '0;
                            remaining <= '0;
                            stall_cnt <= '0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
`endif
                end
                DRAIN: begin
                    done  <= grant;
                    ptr   <= gidx;
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Scoreboard bench for fifo_read_arbiter with a behavioural FIFO on the read port.
module tb_fifo_read_arbiter;

    logic        recv_clk = 1'b0;
    logic        trans_rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] burst_len = '0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  recv_data = '0;
    logic        read_enable;
    logic [3:0]  grant;
    logic [7:0]  out_data;
    logic [3:0]  out_valid;
    logic [3:0]  done;
    logic        busy;
`ifdef ARB_TIMEOUT_EN
    logic [3:0]  abort;
`endif

    typedef struct packed {
        logic [3:0] mask;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] wr_q[$];

    int checks = 0;
    int errors = 0;

    logic [3:0] first_grant;
    logic [3:0] done_val;
    logic [3:0] ov_at_done;
    logic [3:0] abort_at_done;
    int         re_cnt;
    int         cyc_done;

    fifo_read_arbiter #(
        .NUM_REQ(4),
        .DATA_W(8),
        .BURST_W(4)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .recv_clk(recv_clk),
        .trans_rst(trans_rst),
        .req(req),
        .burst_len(burst_len),
        .fifo_empty(fifo_empty),
        .recv_data(recv_data),
        .read_enable(read_enable),
        .grant(grant),
        .out_data(out_data),
        .out_valid(out_valid),
        .done(done),
        .busy(busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .abort(abort)
`endif
    );

    always #5 recv_clk = ~recv_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model: pop on read_enable, data valid the following cycle.
    always @(posedge recv_clk) begin
        if (read_enable && !fifo_empty) recv_data <= fifo_q.pop_front();
        while (wr_q.size() != 0) fifo_q.push_back(wr_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Scoreboard and read-port safety monitor.
    always @(negedge recv_clk) begin
        if (!trans_rst && out_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {28'b0, out_valid}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_valid", {28'b0, out_valid}, {28'b0, e.mask});
                check("sb_data", {24'b0, out_data}, {24'b0, e.data});
            end
        end
        if (read_enable) check("re_while_empty", {31'b0, fifo_empty}, 32'h0);
    end

    task automatic push_words(input logic [3:0] mask, input logic [7:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            wr_q.push_back(base + 8'(j));
            exp_q.push_back('{mask: mask, data: base + 8'(j)});
        end
    endtask

    task automatic do_reset();
        @(negedge recv_clk);
        trans_rst = 1'b1;
        req = '0;
        repeat (2) @(negedge recv_clk);
        trans_rst = 1'b0;
        @(negedge recv_clk);
    endtask

    // Called right after req is driven; drops req once a grant appears.
    task automatic run_until_done(input int max_cyc, input int push_at, input int push_n,
                                  input logic [7:0] push_base);
        logic found;
        found = 1'b0;
        first_grant = '0;
        done_val = '0;
        ov_at_done = '0;
        abort_at_done = '0;
        re_cnt = 0;
        cyc_done = -1;
        for (int k = 1; k <= max_cyc && !found; k++) begin
            @(negedge recv_clk);
            if (read_enable) re_cnt++;
            if (first_grant == '0 && grant != '0) begin
                first_grant = grant;
                req = '0;
            end
            if (k == push_at)
                for (int j = 0; j < push_n; j++) wr_q.push_back(push_base + 8'(j));
            if (done != '0) begin
                found = 1'b1;
                cyc_done = k;
                done_val = done;
                ov_at_done = out_valid;
`ifdef ARB_TIMEOUT_EN
                abort_at_done = abort;
`endif
            end
        end
        check("done_seen", {31'b0, found}, 32'h1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge recv_clk);
        check("rst_grant", {28'b0, grant}, 0);
        check("rst_valid", {28'b0, out_valid}, 0);
        check("rst_done", {28'b0, done}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_re", {31'b0, read_enable}, 0);
        trans_rst = 1'b0;
        @(negedge recv_clk);

        // Single burst of 4 to consumer 1
        push_words(4'b0010, 8'd17, 4);
        repeat (2) @(negedge recv_clk);
        burst_len[1*4 +: 4] = 4'd4;
        req = 4'b0010;
        run_until_done(60, 0, 0, 8'd0);
        check("b1_grant", {28'b0, first_grant}, 32'h2);
        check("b1_done", {28'b0, done_val}, 32'h2);
        check("b1_ov_done", {28'b0, ov_at_done}, 32'h2);
        check("b1_reads", re_cnt, 4);
        check("b1_latency", cyc_done, 7);
        @(negedge recv_clk);
        check("b1_busy_end", {31'b0, busy}, 0);

        // Round-robin with all four requesting
        do_reset();
        burst_len = {4'd2, 4'd2, 4'd2, 4'd2};
        for (int c = 0; c < 4; c++) push_words(4'(1 << c), 8'h30 + 8'(2 * c), 2);
        repeat (2) @(negedge recv_clk);
        req = 4'b1111;
        begin
            int ng, nd;
            logic [3:0] prev;
            ng = 0;
            nd = 0;
            prev = '0;
            for (int k = 0; k < 300 && nd < 4; k++) begin
                @(negedge recv_clk);
                if (grant != '0 && grant != prev) begin
                    check("rr_grant", {28'b0, grant}, 32'(1 << ng));
                    ng++;
                    if (ng == 4) req = '0;
                end
                prev = grant;
                if (done != '0) begin
                    check("rr_done", {28'b0, done}, 32'(1 << nd));
                    nd++;
                end
            end
            check("rr_done_count", nd, 4);
        end

        // Empty stall: 1 word now, 2 more after 10 cycles
        do_reset();
        burst_len = '0;
        burst_len[0 +: 4] = 4'd3;
        wr_q.push_back(8'h41);
        exp_q.push_back('{mask: 4'b0001, data: 8'h41});
        exp_q.push_back('{mask: 4'b0001, data: 8'h42});
        exp_q.push_back('{mask: 4'b0001, data: 8'h43});
        repeat (2) @(negedge recv_clk);
        req = 4'b0001;
        run_until_done(80, 10, 2, 8'h42);
        check("st_done", {28'b0, done_val}, 32'h1);
        check("st_ov_done", {28'b0, ov_at_done}, 32'h1);
        check("st_reads", re_cnt, 3);

        // Zero-length burst, then pointer moves past requester 2
        do_reset();
        burst_len = '0;
        burst_len[3*4 +: 4] = 4'd1;
        req = 4'b0100;
        run_until_done(20, 0, 0, 8'd0);
        check("z_done", {28'b0, done_val}, 32'h4);
        check("z_latency", cyc_done, 2);
        check("z_reads", re_cnt, 0);
        push_words(4'b1000, 8'h55, 1);
        repeat (2) @(negedge recv_clk);
        req = 4'b1001;
        run_until_done(40, 0, 0, 8'd0);
        check("z_next_grant", {28'b0, first_grant}, 32'h8);
        check("z_next_done", {28'b0, done_val}, 32'h8);

        // Reset in the middle of a stalled burst with 5 words remaining
        do_reset();
        burst_len = '0;
        burst_len[0 +: 4] = 4'd7;
        push_words(4'b0001, 8'h60, 2);
        repeat (2) @(negedge recv_clk);
        req = 4'b0001;
        repeat (10) @(negedge recv_clk);
        check("mr_busy_before", {31'b0, busy}, 1);
        trans_rst = 1'b1;
        req = '0;
        #1;
        check("mr_grant", {28'b0, grant}, 0);
        check("mr_busy", {31'b0, busy}, 0);
        check("mr_re", {31'b0, read_enable}, 0);
        check("mr_valid", {28'b0, out_valid}, 0);
        check("mr_done", {28'b0, done}, 0);
        @(negedge recv_clk);
        trans_rst = 1'b0;
        burst_len[0 +: 4] = 4'd1;
        burst_len[3*4 +: 4] = 4'd1;
        push_words(4'b0001, 8'h70, 1);
        repeat (2) @(negedge recv_clk);
        req = 4'b1001;
        run_until_done(40, 0, 0, 8'd0);
        check("mr_first_grant", {28'b0, first_grant}, 32'h1);
        check("mr_after_done", {28'b0, done_val}, 32'h1);

`ifdef ARB_TIMEOUT_EN
        // Empty-stall abort after 2 of 4 words
        do_reset();
        burst_len = '0;
        burst_len[1*4 +: 4] = 4'd4;
        push_words(4'b0010, 8'h80, 2);
        repeat (2) @(negedge recv_clk);
        req = 4'b0010;
        run_until_done(60, 0, 0, 8'd0);
        check("to_done", {28'b0, done_val}, 32'h2);
        check("to_abort", {28'b0, abort_at_done}, 32'h2);
        check("to_reads", re_cnt, 2);
        check("to_latency", cyc_done, 12);
        @(negedge recv_clk);
        check("to_busy_end", {31'b0, busy}, 0);
`endif

        repeat (3) @(negedge recv_clk);
        check("sb_leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
